// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keypad_pkg
// Description : Shared types and constants for the 4x4 matrix keypad scanner.
// Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

    typedef enum logic [2:0] {
        ST_SCAN     = 3'd0,
        ST_DEBOUNCE = 3'd1,
        ST_EMIT     = 3'd2,
        ST_HOLD     = 3'd3,
        ST_RELEASE  = 3'd4
    } kp_state_t;

    localparam int c_SCAN_DIV_DEFAULT     = 48000;
    localparam int c_DEBOUNCE_CYC_DEFAULT = 480000;

    // Indexed by {row, col}; entry 0 is the top-left key.
    localparam logic [15:0][3:0] c_KEY_MAP = {
        4'hD, 4'hF, 4'h0, 4'hE,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    function automatic logic [1:0] lowest_low_col(input logic [3:0] c);
        if (!c[0])      return 2'd0;
        else if (!c[1]) return 2'd1;
        else if (!c[2]) return 2'd2;
        else            return 2'd3;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// ============================================================================
// Module      : sync2
// Description : Two-flop synchronizer, resets to all-ones (idle pulled-up).
// Revision    : 1.0 - initial release
// ============================================================================
module sync2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scanner
// Description : 4x4 keypad row scanner with press/release debounce.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = c_SCAN_DIV_DEFAULT,
    parameter int DEBOUNCE_CYC = c_DEBOUNCE_CYC_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cols,
    output logic [3:0] rows,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int c_DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_CNT_W = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(SCAN_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYC - 1);

    logic [3:0]         w_scols;
    kp_state_t          r_state,    w_state_nxt;
    logic [1:0]         r_row,      w_row_nxt;
    logic [1:0]         r_col,      w_col_nxt;
    logic [c_DIV_W-1:0] r_div,      w_div_nxt;
    logic [c_CNT_W-1:0] r_cnt,      w_cnt_nxt;
    logic [3:0]         r_key_code, w_code_nxt;
    logic               r_key_valid, w_valid_nxt;
    logic               r_key_held,  w_held_nxt;

    sync2 #(
        .WIDTH (4)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (cols),
        .o_q   (w_scols)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_SCAN;
            r_row       <= 2'd0;
            r_col       <= 2'd0;
            r_div       <= '0;
            r_cnt       <= '0;
            r_key_code  <= 4'h0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_row       <= w_row_nxt;
            r_col       <= w_col_nxt;
            r_div       <= w_div_nxt;
            r_cnt       <= w_cnt_nxt;
            r_key_code  <= w_code_nxt;
            r_key_valid <= w_valid_nxt;
            r_key_held  <= w_held_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        w_div_nxt   = r_div;
        w_cnt_nxt   = r_cnt;
        w_code_nxt  = r_key_code;
        w_valid_nxt = 1'b0;
        w_held_nxt  = r_key_held;

        case (r_state)
            ST_SCAN: begin
                // Columns are only trusted at slot end, after the synchronizer settles.
                if (r_div == c_DIV_LAST) begin
                    if (w_scols != 4'hF) begin
                        w_state_nxt = ST_DEBOUNCE;
                        w_col_nxt   = lowest_low_col(w_scols);
                        w_cnt_nxt   = '0;
                    end else begin
                        w_row_nxt = r_row + 2'd1;
                        w_div_nxt = '0;
                    end
                end else begin
                    w_div_nxt = r_div + 1'b1;
                end
            end

            ST_DEBOUNCE: begin
                if (w_scols[r_col]) begin
                    w_state_nxt = ST_SCAN;
                    w_row_nxt   = r_row + 2'd1;
                    w_div_nxt   = '0;
                    w_cnt_nxt   = '0;
                end else if (r_cnt >= c_CNT_LAST) begin
                    w_state_nxt = ST_EMIT;
                    w_code_nxt  = c_KEY_MAP[{r_row, r_col}];
                    w_valid_nxt = 1'b1;
                    w_held_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            ST_EMIT: begin
                w_state_nxt = ST_HOLD;
                w_cnt_nxt   = '0;
            end

            ST_HOLD: begin
                if (w_scols == 4'hF) begin
                    w_state_nxt = ST_RELEASE;
                    w_cnt_nxt   = '0;
                end
            end

            ST_RELEASE: begin
                if (w_scols != 4'hF) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = '0;
                end else if (r_cnt >= c_CNT_LAST) begin
                    w_state_nxt = ST_SCAN;
                    w_held_nxt  = 1'b0;
                    w_row_nxt   = r_row + 2'd1;
                    w_div_nxt   = '0;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            default: begin
                w_state_nxt = ST_SCAN;
            end
        endcase
    end

    always_comb begin
        rows = ~(4'b0001 << r_row);
    end

    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_scanner
// Description : Self-checking bench: keypad matrix model plus key-event checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CYC = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] cols;
    logic [3:0] rows;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [3:0][3:0] pressed = '0;   // [row][col]

    int  n_vec = 0;
    int  n_err = 0;
    int  pulse_cnt = 0;
    bit  prev_valid = 1'b0;

    always #5 clk = ~clk;

    keypad_scanner #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cols      (cols),
        .rows      (rows),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    // Passive matrix: a pressed key shorts its column to any driven (low) row.
    always_comb begin
        cols = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (!rows[r]) begin
                for (int c = 0; c < 4; c++) begin
                    if (pressed[r][c]) cols[c] = 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] model_code(input int r, input int c);
        if (c == 3) return 4'(10 + r);
        if (r < 3)  return 4'(1 + 3 * r + c);
        case (c)
            0:       return 4'hE;
            1:       return 4'h0;
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [3:0] row_drive(input int r);
        logic [3:0] v;
        v = 4'b0001 << r;
        return ~v;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            check("rows_onecold", 32'($countones(~rows)), 1);
            if (key_valid) begin
                pulse_cnt++;
                check("valid_held", key_held, 1);
                check("valid_width", prev_valid, 0);
            end
        end
        prev_valid = key_valid && !reset;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_pulse(input int base, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick(1);
            if (pulse_cnt != base) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_held_low(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick(1);
            if (!key_held) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_row_start(input int r, input int budget, output bit ok);
        logic [3:0] p;
        p  = rows;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick(1);
            if (rows == row_drive(r) && p != row_drive(r)) begin
                ok = 1'b1;
                break;
            end
            p = rows;
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_rows"},  rows, 4'b1110);
        check({tag, "_code"},  key_code, 4'h0);
        check({tag, "_valid"}, key_valid, 0);
        check({tag, "_held"},  key_held, 0);
    endtask

    task automatic press_and_release(input int r, input int c, input int extra);
        int base;
        bit ok;
        base = pulse_cnt;
        pressed[r][c] = 1'b1;
        wait_pulse(base, 200, ok);
        check("press_seen", ok, 1);
        check("press_valid", key_valid, 1);
        check("press_code", key_code, model_code(r, c));
        tick(5 + extra);
        check("press_rows_frozen", rows, row_drive(r));
        check("press_held", key_held, 1);
        check("press_one_pulse", pulse_cnt - base, 1);
        pressed[r][c] = 1'b0;
        wait_held_low(100, ok);
        check("release_seen", ok, 1);
        check("release_next_row", rows, row_drive((r + 1) % 4));
        check("release_pulses", pulse_cnt - base, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit         ok;
        int         base;
        int         dwell;
        logic [3:0] exp_rows;

        reset = 1'b1;
        tick(3);
        check_reset("rst_init");
        reset = 1'b0;

        // Idle scan: one slot per SCAN_DIV cycles, rotating 0..3.
        wait_row_start(1, 10, ok);
        check("scan_start", ok, 1);
        exp_rows = 4'b1101;
        for (int slot = 0; slot < 12; slot++) begin
            for (int j = 0; j < SCAN_DIV; j++) begin
                if (slot != 0 || j != 0) tick(1);
                check("scan_seq", rows, exp_rows);
            end
            exp_rows = {exp_rows[2:0], exp_rows[3]};
        end
        check("idle_no_valid", pulse_cnt, 0);

        press_and_release(2, 1, 20);

        // Bounce: 5 low cycles must be rejected, scan continues at next row.
        wait_row_start(2, 40, ok);
        check("bounce_row_start", ok, 1);
        base = pulse_cnt;
        pressed[2][1] = 1'b1;
        tick(5);
        pressed[2][1] = 1'b0;
        dwell = 6;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (rows != 4'b1011) break;
            dwell++;
        end
        check("bounce_detected", dwell > SCAN_DIV, 1);
        check("bounce_next_row", rows, 4'b0111);
        tick(10);
        check("bounce_no_valid", pulse_cnt - base, 0);
        check("bounce_held", key_held, 0);

        // Release glitch restarts the release debounce.
        base = pulse_cnt;
        pressed[1][2] = 1'b1;
        wait_pulse(base, 200, ok);
        check("glitch_press_seen", ok, 1);
        check("glitch_code", key_code, model_code(1, 2));
        tick(10);
        pressed[1][2] = 1'b0;
        tick(4);
        pressed[1][2] = 1'b1;
        tick(3);
        pressed[1][2] = 1'b0;
        check("glitch_held", key_held, 1);
        tick(DEBOUNCE_CYC - 1);
        check("glitch_early_release", key_held, 1);
        wait_held_low(20, ok);
        check("glitch_release_seen", ok, 1);
        check("glitch_pulses", pulse_cnt - base, 1);
        check("glitch_next_row", rows, row_drive(2));

        // Second key while held is ignored.
        base = pulse_cnt;
        pressed[3][0] = 1'b1;
        wait_pulse(base, 200, ok);
        check("multi_press_seen", ok, 1);
        check("multi_code_star", key_code, model_code(3, 0));
        pressed[0][3] = 1'b1;
        tick(30);
        check("multi_one_pulse", pulse_cnt - base, 1);
        check("multi_code_kept", key_code, 4'hE);
        check("multi_held", key_held, 1);
        check("multi_rows_frozen", rows, 4'b0111);
        pressed = '0;
        wait_held_low(100, ok);
        check("multi_release_seen", ok, 1);
        press_and_release(0, 3, 0);
        check("multi_code_a", key_code, 4'hA);

        // Reset mid-debounce aborts, held key is found again afterwards.
        wait_row_start(2, 40, ok);
        check("rst_row_start", ok, 1);
        pressed[2][1] = 1'b1;
        tick(6);
        base  = pulse_cnt;
        reset = 1'b1;
        tick(1);
        check_reset("rst_debounce");
        reset = 1'b0;
        check("rst_no_valid", pulse_cnt - base, 0);
        wait_pulse(base, 200, ok);
        check("rst_redetect", ok, 1);
        check("rst_redetect_code", key_code, 4'h8);
        pressed[2][1] = 1'b0;
        wait_held_low(100, ok);
        check("rst_release_seen", ok, 1);

        for (int k = 0; k < 6; k++) begin
            press_and_release(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                              int'($urandom_range(0, 15)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 48000, meaning clk cycles per row slot; legal values >= 4.
REQ-002 SHALL have parameter DEBOUNCE_CYC, default 480000, meaning consecutive stable cycles required for press and for release.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state on rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-005 SHALL have port cols, input, 4 bits: keypad columns, asynchronous, active-low, pulled up; bit i = column i, column 0 leftmost.
REQ-006 SHALL have port rows, output, 4 bits: row drive, exactly one bit low; bit r low = row r driven, row 0 top.
REQ-007 SHALL have port key_code, output, 4 bits: code of last accepted key, held until the next accepted key.
REQ-008 SHALL have port key_valid, output, 1 bit: one-cycle pulse per accepted press; consumed by the password FSM.
REQ-009 SHALL have port key_held, output, 1 bit: high from the key_valid cycle until release is debounced.

Function
REQ-010 SHALL pass cols through a 2-flop synchronizer; all decisions use the synchronized value (scols).
REQ-011 SHALL implement states SCAN, DEBOUNCE, EMIT, HOLD, RELEASE.
REQ-012 SCAN: rows SHALL advance one row per SCAN_DIV cycles, order 0,1,2,3,0.
REQ-013 SCAN SHALL sample scols only on the last cycle of a slot; any low bit -> latch row and lowest-index low column, go DEBOUNCE, rows frozen.
REQ-014 DEBOUNCE SHALL count cycles with the latched column low; the column going high SHALL return to SCAN at the next row with the count cleared.
REQ-015 DEBOUNCE count reaching DEBOUNCE_CYC SHALL go EMIT.
REQ-016 EMIT SHALL last one cycle, with key_valid=1 and key_code updated in that same cycle.
REQ-017 The key map SHALL be: row0 1,2,3,A; row1 4,5,6,B; row2 7,8,9,C; row3 *,0,#,D.
REQ-018 Codes SHALL be: digits -> 0x0-0x9, A-D -> 0xA-0xD, * -> 0xE, # -> 0xF.
REQ-019 HOLD SHALL keep rows frozen; scols all high SHALL go RELEASE.
REQ-020 RELEASE SHALL count cycles with scols all high; any low bit SHALL return to HOLD with the count cleared.
REQ-021 RELEASE count reaching DEBOUNCE_CYC SHALL clear key_held and go SCAN at the next row.
REQ-022 Additional keys pressed while in DEBOUNCE/HOLD/RELEASE SHALL be ignored; no second key_valid until full release.
REQ-023 Counters SHALL saturate at their terminal values and never wrap.

Reset
REQ-024 Reset SHALL force, on the next edge: rows=4'b1110, key_code=0x0, key_valid=0, key_held=0, state SCAN, counters 0, synchronizer flops 4'b1111.
REQ-025 Reset asserted mid-press (any state) SHALL abort without a key_valid pulse; a key still held after reset SHALL be re-detected via the normal SCAN/DEBOUNCE path.

Structure
REQ-026 Package keypad_pkg SHALL hold the state enum, the 16-entry key-code map constant, and the default SCAN_DIV/DEBOUNCE_CYC values.
REQ-027 The synchronizer SHALL be sub-module sync2 (parameterized width, reset value all-ones); all other logic SHALL be in keypad_scanner.

Verification (SCAN_DIV=4, DEBOUNCE_CYC=8)
REQ-028 Reset, cols=4'b1111 -> rows cycles 1110,1101,1011,0111 every 4 cycles; key_valid never high.
REQ-029 Hold cols=4'b1101 while rows=4'b1011 for >=20 cycles -> one key_valid pulse, key_code=0x8, key_held=1; rows frozen at 4'b1011.
REQ-030 Column low 5 cycles then high (bounce) -> no key_valid; scan resumes at the next row.
REQ-031 Release with a 3-cycle low glitch inside the release window, then stable high 8 cycles -> key_held clears only after the final 8 stable cycles; exactly one key_valid total.
REQ-032 Press row3 col0, then press row0 col3 while held -> key_code=0xE only; after full release, key row0 col3 -> key_code=0xA.
REQ-033 Assert reset during DEBOUNCE -> no key_valid; outputs match the REQ-024 values on the next edge.
